// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } par_t;

    typedef enum logic [1:0] {
        BITS_5 = 2'b00,
        BITS_6 = 2'b01,
        BITS_7 = 2'b10,
        BITS_8 = 2'b11
    } bits_t;

    function automatic logic [2:0] last_index(input bits_t bits);
        return 3'd4 + {1'b0, bits};
    endfunction

    // Only the configured low-order data bits take part in the parity.
    function automatic logic parity_bit(input logic [7:0] data, input bits_t bits, input par_t mode);
        logic [7:0] mask;
        mask = 8'hFF >> (3'd3 - {1'b0, bits});
        return (^(data & mask)) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte handshake between the TX FIFO read side and the transmitter.
interface uart_tx_cfg_if;

    logic       i_Valid;
    logic [7:0] i_Data;
    logic       o_Ready;

    modport master (output i_Valid, output i_Data, input o_Ready);
    modport slave  (input i_Valid, input i_Data, output o_Ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: restarts on clear, strobes bit_end on the last cycle of each bit.
module uart_baud_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] div,
    output logic             bit_end
);

    logic [CNT_W-1:0] count;

    assign bit_end = (count == div - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst || clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, parity, 1/2 stop bits, baud divisor, CTS).
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int RESET_DIV = 217
) (
    input  logic             i_Clock,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_Cfg_Div,
    input  logic [1:0]       i_Cfg_Bits,
    input  logic [1:0]       i_Cfg_Par,
    input  logic             i_Cfg_Stop2,
    input  logic             i_CTS,
    uart_tx_cfg_if.slave     bus,
    output logic             o_TX_Serial,
    output logic             o_TX_Active,
    output logic             o_TX_Done
);

    state_t           state, state_next;
    logic [2:0]       bit_idx, idx_next;
    logic             stop_cnt, stop_next;
    logic             serial_next, done_next;
    logic             accept, bit_end, par_en;
    logic [7:0]       data_reg;
    logic [CNT_W-1:0] div_reg, div_clamped;
    bits_t            bits_reg;
    par_t             par_reg;
    logic             stop2_reg;

    assign div_clamped = (i_Cfg_Div < CNT_W'(2)) ? CNT_W'(RESET_DIV) : i_Cfg_Div;
    assign bus.o_Ready = rst && i_CTS && (state == ST_IDLE);
    assign accept      = bus.i_Valid && bus.o_Ready;
    assign o_TX_Active = (state != ST_IDLE);
    assign par_en      = (par_reg == PAR_EVEN) || (par_reg == PAR_ODD);

    uart_baud_gen #(.CNT_W(CNT_W)) baud (
        .clk     (i_Clock),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .div     (div_reg),
        .bit_end (bit_end)
    );

    always_comb begin
        state_next = state;
        idx_next   = bit_idx;
        stop_next  = stop_cnt;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_START;
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                    idx_next   = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == last_index(bits_reg)) begin
                        state_next = par_en ? ST_PARITY : ST_STOP;
                        stop_next  = 1'b0;
                    end else begin
                        idx_next = bit_idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                    stop_next  = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_reg && !stop_cnt) stop_next = 1'b1;
                    else                        state_next = ST_IDLE;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    // The line is registered, so its next value follows the state being entered.
    always_comb begin
        serial_next = 1'b1;
        done_next   = (state == ST_STOP) && (state_next == ST_IDLE);
        case (state_next)
            ST_START:  serial_next = 1'b0;
            ST_DATA:   serial_next = data_reg[idx_next];
            ST_PARITY: serial_next = parity_bit(data_reg, bits_reg, par_reg);
            default:   serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!rst) begin
            state       <= ST_IDLE;
            bit_idx     <= '0;
            stop_cnt    <= 1'b0;
            o_TX_Serial <= 1'b1;
            o_TX_Done   <= 1'b0;
            data_reg    <= '0;
            div_reg     <= '0;
            bits_reg    <= BITS_5;
            par_reg     <= PAR_NONE;
            stop2_reg   <= 1'b0;
        end else begin
            state       <= state_next;
            bit_idx     <= idx_next;
            stop_cnt    <= stop_next;
            o_TX_Serial <= serial_next;
            o_TX_Done   <= done_next;
            if (accept) begin
                data_reg  <= bus.i_Data;
                div_reg   <= div_clamped;
                bits_reg  <= bits_t'(i_Cfg_Bits);
                par_reg   <= par_t'(i_Cfg_Par);
                stop2_reg <= i_Cfg_Stop2;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues expected line patterns, a monitor checks each frame.
module tb_uart_tx_cfg;

    localparam int CNT_W = 16;
    localparam int BOUND = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] cfg_div;
    logic [1:0]       cfg_bits;
    logic [1:0]       cfg_par;
    logic             cfg_stop2;
    logic             cts;
    logic             tx_serial;
    logic             tx_active;
    logic             tx_done;

    uart_tx_cfg_if bus();

    uart_tx_cfg #(.CNT_W(CNT_W), .RESET_DIV(217)) dut (
        .i_Clock     (clk),
        .rst         (rst),
        .i_Cfg_Div   (cfg_div),
        .i_Cfg_Bits  (cfg_bits),
        .i_Cfg_Par   (cfg_par),
        .i_Cfg_Stop2 (cfg_stop2),
        .i_CTS       (cts),
        .bus         (bus),
        .o_TX_Serial (tx_serial),
        .o_TX_Active (tx_active),
        .o_TX_Done   (tx_done)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    string pat_q[$];
    int    div_q[$];
    bit    mon_busy = 1'b0;
    bit    prev_active = 1'b0;
    string cur_pat;
    int    cur_div;
    int    mcyc;
    int    flen;
    int    frame_no = 0;
    bit    bit_err;
    logic [3:0] err_got, now_v, want_v;
    int    cyc_now = 0;
    int    done_count = 0;
    int    last_done_cyc = -10;
    int    last_start_cyc = 0;

    function automatic void check_output(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, got, want);
        end
    endfunction

    // Monitor: pops an expected pattern when a frame starts and checks every cycle of it.
    always @(negedge clk) begin
        cyc_now++;
        if (!rst) begin
            mon_busy    = 1'b0;
            prev_active = 1'b0;
        end else begin
            if (!mon_busy && tx_active && !prev_active) begin
                if (pat_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_frame: active=1 with nothing queued, want active=0");
                end else begin
                    cur_pat        = pat_q.pop_front();
                    cur_div        = div_q.pop_front();
                    mon_busy       = 1'b1;
                    mcyc           = 0;
                    bit_err        = 1'b0;
                    frame_no++;
                    last_start_cyc = cyc_now;
                end
            end else if (!mon_busy && tx_done) begin
                total++;
                bad++;
                $display("[TB] FAIL stray_done: done=1 outside a frame end, want 0");
            end
            if (mon_busy) begin
                flen  = cur_pat.len() * cur_div;
                now_v = {tx_serial, tx_active, tx_done, bus.o_Ready};
                if (mcyc < flen) begin
                    want_v = {(cur_pat[mcyc / cur_div] == 8'h31), 3'b100};
                    if (now_v !== want_v && !bit_err) begin
                        bit_err = 1'b1;
                        err_got = now_v;
                    end
                    if (mcyc % cur_div == cur_div - 1) begin
                        check_output($sformatf("frame%0d_bit%0d {serial,active,done,ready}",
                                               frame_no, mcyc / cur_div),
                                     {28'd0, bit_err ? err_got : now_v}, {28'd0, want_v});
                        bit_err = 1'b0;
                    end
                end else begin
                    check_output($sformatf("frame%0d_end {serial,active,done}", frame_no),
                                 {29'd0, now_v[3:1]}, 32'h5);
                    if (tx_done) done_count++;
                    last_done_cyc = cyc_now;
                    mon_busy      = 1'b0;
                end
                mcyc++;
            end
            prev_active = tx_active;
        end
    end

    task automatic apply_stimulus(input logic [7:0] d, input logic [CNT_W-1:0] div,
                                  input logic [1:0] bits, input logic [1:0] par,
                                  input logic stop2, input string pat, input int exp_div);
        int n;
        @(negedge clk); #1;
        cfg_div     = div;
        cfg_bits    = bits;
        cfg_par     = par;
        cfg_stop2   = stop2;
        bus.i_Data  = d;
        bus.i_Valid = 1'b1;
        pat_q.push_back(pat);
        div_q.push_back(exp_div);
        n = 0;
        while (!bus.o_Ready && n < BOUND) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= BOUND) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: ready=0 after %0d cycles, want 1", n);
            void'(pat_q.pop_back());
            void'(div_q.pop_back());
            bus.i_Valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.i_Valid = 1'b0;
        bus.i_Data  = 8'hFF;
        cfg_div     = 16'd7;
        cfg_bits    = 2'b00;
        cfg_par     = 2'b10;
        cfg_stop2   = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((pat_q.size() != 0 || mon_busy) && n < BOUND) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= BOUND) begin
            total++;
            bad++;
            $display("[TB] FAIL idle_timeout: frames still pending=%0d busy=%0d, want 0 0",
                     pat_q.size(), mon_busy);
        end
    endtask

    initial begin
        int   gap;
        logic err;
        rst         = 1'b0;
        cts         = 1'b1;
        bus.i_Valid = 1'b0;
        bus.i_Data  = 8'h00;
        cfg_div     = 16'd4;
        cfg_bits    = 2'b11;
        cfg_par     = 2'b00;
        cfg_stop2   = 1'b0;

        repeat (2) @(negedge clk);
        check_output("reset_serial", {31'd0, tx_serial}, 32'd1);
        check_output("reset_ready", {31'd0, bus.o_Ready}, 32'd0);
        check_output("reset_active", {31'd0, tx_active}, 32'd0);
        check_output("reset_done", {31'd0, tx_done}, 32'd0);
        #1 rst = 1'b1;

        apply_stimulus(8'hA5, 16'd4, 2'b11, 2'b00, 1'b0, "0101001011", 4);
        wait_idle();
        apply_stimulus(8'h41, 16'd4, 2'b10, 2'b01, 1'b0, "0100000101", 4);
        wait_idle();
        apply_stimulus(8'hF3, 16'd3, 2'b00, 2'b10, 1'b1, "011001011", 3);
        wait_idle();

        // Flow control: a held byte must wait for CTS, and CTS dropping mid-frame changes nothing.
        @(negedge clk); #1;
        cts         = 1'b0;
        cfg_div     = 16'd2;
        cfg_bits    = 2'b11;
        cfg_par     = 2'b00;
        cfg_stop2   = 1'b0;
        bus.i_Data  = 8'h3C;
        bus.i_Valid = 1'b1;
        err         = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_Ready !== 1'b0 || tx_serial !== 1'b1 || tx_active !== 1'b0) err = 1'b1;
        end
        check_output("cts_low_hold {ready,serial,active}",
                     err ? {29'd0, bus.o_Ready, tx_serial, tx_active} : 32'h2, 32'h2);
        #1;
        pat_q.push_back("0001111001");
        div_q.push_back(2);
        cts = 1'b1;
        @(posedge clk); #1;
        bus.i_Valid = 1'b0;
        check_output("cts_raise_accept_active", {31'd0, tx_active}, 32'd1);
        repeat (5) @(negedge clk);
        #1 cts = 1'b0;
        wait_idle();
        #1 cts = 1'b1;

        apply_stimulus(8'h55, 16'd2, 2'b11, 2'b00, 1'b0, "0101010101", 2);
        apply_stimulus(8'hAA, 16'd2, 2'b11, 2'b00, 1'b0, "0010101011", 2);
        @(negedge clk); #1;
        gap = last_start_cyc - last_done_cyc;
        check_output("b2b_idle_gap_cycles", gap, 32'd1);
        wait_idle();

        apply_stimulus(8'hF0, 16'd4, 2'b11, 2'b00, 1'b0, "0000011111", 4);
        repeat (17) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("midframe_reset {serial,active,done,ready}",
                     {28'd0, tx_serial, tx_active, tx_done, bus.o_Ready}, 32'h8);
        @(negedge clk);
        check_output("midframe_reset_no_done", {31'd0, tx_done}, 32'd0);
        #1 rst = 1'b1;
        apply_stimulus(8'h0F, 16'd4, 2'b11, 2'b00, 1'b0, "0111100001", 4);
        wait_idle();

        apply_stimulus(8'h0A, 16'd0, 2'b00, 2'b00, 1'b0, "0010101", 217);
        wait_idle();

        repeat (3) @(negedge clk);
        check_output("done_pulse_count", done_count, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
